// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the instruction fetch/decode sequencer:
// instruction classes, FSM states and the datapath control-word layout.
package cpu_control_unit_pkg;

    localparam int unsigned IR_W   = 16;
    localparam int unsigned CTRL_W = 14;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOADI = 2'b01,
        CLS_JMP   = 2'b10,
        CLS_HALT  = 2'b11
    } instr_class_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // Field order matches the datapath: {sel_a, sel_b, dst, alu_op}
    typedef struct packed {
        logic [2:0] sel_a;
        logic [2:0] sel_b;
        logic [2:0] dst;
        logic [4:0] alu_op;
    } ctrl_word_t;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction decoder: IR -> control word, immediate,
// and jump/halt flags with jump target.
module cpu_instr_decoder
    import cpu_control_unit_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [IR_W-1:0]   ir_i,
    output ctrl_word_t        control_o,
    output logic [DATA_W-1:0] data_o,
    output logic              is_jmp_o,
    output logic              is_halt_o,
    output logic [PC_W-1:0]   target_o
);

    instr_class_e cls;
    assign cls = instr_class_e'(ir_i[15:14]);

    always_comb begin
        control_o = ctrl_word_t'(CTRL_NOP);
        data_o    = '0;
        is_jmp_o  = 1'b0;
        is_halt_o = 1'b0;
        target_o  = ir_i[PC_W-1:0];
        case (cls)
            CLS_ALU:   control_o = ctrl_word_t'(ir_i[13:0]);
            CLS_LOADI: begin
                control_o.dst = ir_i[7:5];
                data_o        = ir_i[3:0];
            end
            CLS_JMP:   is_jmp_o  = 1'b1;
            CLS_HALT:  is_halt_o = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer: fetches instructions over a req/valid
// handshake and presents one decoded control word per EXEC cycle.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [CTRL_W-1:0]  control,
    output logic [DATA_W-1:0]  data_out,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;

    ctrl_word_t          dec_control;
    logic [DATA_W-1:0]   dec_data;
    logic                dec_is_jmp;
    logic                dec_is_halt;
    logic [PC_W-1:0]     dec_target;

    cpu_instr_decoder #(
        .PC_W (PC_W)
    ) u_decoder (
        .ir_i      (ir_q[IR_W-1:0]),
        .control_o (dec_control),
        .data_o    (dec_data),
        .is_jmp_o  (dec_is_jmp),
        .is_halt_o (dec_is_halt),
        .target_o  (dec_target)
    );

    // Next-state, pc and control-word staging; control is nonzero only in EXEC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ctrl_d  = CTRL_NOP;
        data_d  = '0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl_d  = dec_control;
                data_d  = dec_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_is_halt) begin
                    state_d = ST_HALTED;
                end else if (dec_is_jmp) begin
                    pc_d    = dec_target;
                    state_d = ST_FETCH;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d    = (state_d == ST_FETCH);
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            ctrl_q   <= CTRL_NOP;
            data_q   <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_req  = req_q;
    assign control   = ctrl_q;
    assign data_out  = data_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: an 8-bit-pc instance with a
// variable-latency memory and a 2-bit-pc instance for wrap-around.
module tb_cpu_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Instance A: PC_W = 8
    logic        start_a = 1'b0;
    logic [7:0]  addr_a, pc_a;
    logic        req_a, valid_a, busy_a, halted_a;
    logic [15:0] rdata_a;
    logic [13:0] ctrl_a;
    logic [3:0]  data_a;

    // Instance B: PC_W = 2
    logic        start_b = 1'b0;
    logic [1:0]  addr_b, pc_b;
    logic        req_b, valid_b, busy_b, halted_b;
    logic [15:0] rdata_b;
    logic [13:0] ctrl_b;
    logic [3:0]  data_b;

    cpu_control_unit #(.PC_W(8), .INSTR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .imem_addr(addr_a), .imem_req(req_a),
        .imem_rdata(rdata_a), .imem_valid(valid_a), .control(ctrl_a), .data_out(data_a),
        .pc(pc_a), .busy(busy_a), .halted(halted_a)
    );

    cpu_control_unit #(.PC_W(2), .INSTR_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .imem_addr(addr_b), .imem_req(req_b),
        .imem_rdata(rdata_b), .imem_valid(valid_b), .control(ctrl_b), .data_out(data_b),
        .pc(pc_b), .busy(busy_b), .halted(halted_b)
    );

    // Memory model A: valid on the lat_a-th cycle of a request
    logic [15:0] mem_a [256];
    int   lat_a = 1;
    int   wait_a = 0;
    bit   auto_a = 1'b1;
    logic mem_valid_a = 1'b0;
    logic man_valid_a = 1'b0;
    logic prev_req_a = 1'b0;
    int   drop_err_a = 0;
    bit   fetched_a [256];

    assign valid_a = auto_a ? mem_valid_a : man_valid_a;
    assign rdata_a = mem_a[addr_a];

    always @(negedge clk) begin
        if (prev_req_a && !req_a && !mem_valid_a) drop_err_a++;
        prev_req_a = req_a;
        if (req_a && !mem_valid_a) begin
            wait_a++;
            if (wait_a >= lat_a) begin
                mem_valid_a = 1'b1;
                fetched_a[addr_a] = 1'b1;
            end
        end else begin
            mem_valid_a = 1'b0;
            wait_a = 0;
        end
    end

    // Memory model B: 1-cycle latency, address 0 becomes HALT after address 3 is fetched
    logic mem_valid_b = 1'b0;
    bit   wrap_pass_b = 1'b0;
    assign valid_b = mem_valid_b;
    assign rdata_b = (addr_b == 2'd0 && wrap_pass_b) ? 16'hC000 : 16'h4021;

    always @(negedge clk) begin
        if (req_b && !mem_valid_b) begin
            mem_valid_b = 1'b1;
            if (addr_b == 2'd3) wrap_pass_b = 1'b1;
        end else begin
            mem_valid_b = 1'b0;
        end
    end

    // EXEC monitors: record every nonzero control word
    logic [13:0] qa_ctrl[$];
    logic [3:0]  qa_data[$];
    int          qa_cyc[$];
    logic [13:0] qb_ctrl[$];
    logic [3:0]  qb_data[$];
    logic [1:0]  qb_pc[$];

    always @(negedge clk) begin
        cyc++;
        if (ctrl_a != 14'd0) begin
            qa_ctrl.push_back(ctrl_a);
            qa_data.push_back(data_a);
            qa_cyc.push_back(cyc);
        end
        if (ctrl_b != 14'd0) begin
            qb_ctrl.push_back(ctrl_b);
            qb_data.push_back(data_b);
            qb_pc.push_back(pc_b);
        end
    end

    logic [13:0] exp_ctrl [3] = '{14'h0020, 14'h0040, 14'h1162};
    logic [3:0]  exp_data [3] = '{4'd8, 4'd10, 4'd0};

    task automatic load_main_a();
        foreach (mem_a[i]) mem_a[i] = 16'hC000;
        mem_a[0] = 16'h4028;
        mem_a[1] = 16'h404A;
        mem_a[2] = 16'h1162;
        mem_a[3] = 16'hC000;
    endtask

    task automatic clear_qa();
        qa_ctrl.delete();
        qa_data.delete();
        qa_cyc.delete();
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        #1;
    endtask

    task automatic wait_halt_a(input int budget, input string nm);
        int n = 0;
        while (!halted_a && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (halted_a !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt_timeout: halted=%0b expected 1", nm, halted_a);
        end
    endtask

    task automatic check_seq_a(input string nm);
        checks++;
        if (qa_ctrl.size() != 3) begin
            errors++;
            $display("FAIL %s_count: got %0d exec words, expected 3", nm, qa_ctrl.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (qa_ctrl[i] !== exp_ctrl[i] || qa_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL %s_exec%0d: control=%h data=%h expected control=%h data=%h",
                             nm, i, qa_ctrl[i], qa_data[i], exp_ctrl[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_a, busy_a, halted_a, ctrl_a, data_a, pc_a} !== '0 ||
            {req_b, busy_b, halted_b, ctrl_b, data_b, pc_b} !== '0) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h expected 0",
                     {req_a, busy_a, halted_a, ctrl_a, data_a, pc_a},
                     {req_b, busy_b, halted_b, ctrl_b, data_b, pc_b});
        end
        rst_n = 1'b1;
        load_main_a();
        lat_a = 10;
        pulse_start_a();
        @(negedge clk);
        #1;
        checks++;
        if (req_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_fetch_entry: req=%0b busy=%0b expected 1 1", req_a, busy_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_a !== 1'b0 || busy_a !== 1'b0 || pc_a !== 8'd0 || ctrl_a !== 14'd0) begin
            errors++;
            $display("FAIL reset_midfetch: req=%0b busy=%0b pc=%h ctrl=%h expected all 0",
                     req_a, busy_a, pc_a, ctrl_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        auto_a = 1'b0;
        @(negedge clk);
        man_valid_a = 1'b1;
        @(negedge clk);
        man_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_a !== 1'b0 || busy_a !== 1'b0 || halted_a !== 1'b0 || ctrl_a !== 14'd0) begin
            errors++;
            $display("FAIL reset_late_valid: req=%0b busy=%0b halted=%0b ctrl=%h expected 0 0 0 0",
                     req_a, busy_a, halted_a, ctrl_a);
        end
        auto_a = 1'b1;
        lat_a = 1;
    endtask

    task automatic test_program(input int lat, input string nm);
        load_main_a();
        lat_a = lat;
        clear_qa();
        drop_err_a = 0;
        pulse_start_a();
        wait_halt_a(200, nm);
        check_seq_a(nm);
        if (qa_cyc.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (qa_cyc[i] - qa_cyc[i-1] != lat + 2) begin
                    errors++;
                    $display("FAIL %s_cycles%0d: got %0d cycles, expected %0d",
                             nm, i, qa_cyc[i] - qa_cyc[i-1], lat + 2);
                end
            end
        end
        checks++;
        if (pc_a !== 8'd3 || busy_a !== 1'b0 || ctrl_a !== 14'd0) begin
            errors++;
            $display("FAIL %s_final: pc=%h busy=%0b ctrl=%h expected 03 0 0000", nm, pc_a, busy_a, ctrl_a);
        end
        checks++;
        if (drop_err_a != 0) begin
            errors++;
            $display("FAIL %s_req_held: req dropped early %0d times, expected 0", nm, drop_err_a);
        end
        lat_a = 1;
    endtask

    task automatic test_jump();
        foreach (mem_a[i]) mem_a[i] = 16'hC000;
        mem_a[0] = 16'h8002;
        mem_a[1] = 16'h4028;
        mem_a[2] = 16'hC000;
        foreach (fetched_a[i]) fetched_a[i] = 1'b0;
        clear_qa();
        pulse_start_a();
        wait_halt_a(100, "jump");
        checks++;
        if (fetched_a[1] !== 1'b0 || fetched_a[0] !== 1'b1 || fetched_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL jump_fetches: f0=%0b f1=%0b f2=%0b expected 1 0 1",
                     fetched_a[0], fetched_a[1], fetched_a[2]);
        end
        checks++;
        if (pc_a !== 8'd2 || qa_ctrl.size() != 0) begin
            errors++;
            $display("FAIL jump_final: pc=%h words=%0d expected 02 0", pc_a, qa_ctrl.size());
        end
    endtask

    task automatic test_back_to_back();
        load_main_a();
        clear_qa();
        pulse_start_a();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_busy: busy=%0b expected 1", busy_a);
        end
        pulse_start_a();
        wait_halt_a(200, "busy_start");
        check_seq_a("busy_start");
        checks++;
        if (pc_a !== 8'd3) begin
            errors++;
            $display("FAIL busy_start_pc: pc=%h expected 03", pc_a);
        end
    endtask

    task automatic test_restart();
        clear_qa();
        pulse_start_a();
        checks++;
        if (halted_a !== 1'b0 || busy_a !== 1'b1 || addr_a !== 8'd0 || req_a !== 1'b1) begin
            errors++;
            $display("FAIL restart_entry: halted=%0b busy=%0b addr=%h req=%0b expected 0 1 00 1",
                     halted_a, busy_a, addr_a, req_a);
        end
        wait_halt_a(200, "restart");
        check_seq_a("restart");
    endtask

    task automatic test_halt_start_edge();
        int n = 0;
        bit found = 1'b0;
        pulse_start_a();
        while (!found && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (valid_a && addr_a == 8'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL halt_edge_timeout: fetch of address 3 not seen, expected within 100 cycles");
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b1 || ctrl_a !== 14'd0 || halted_a !== 1'b0) begin
            errors++;
            $display("FAIL halt_edge_exec: busy=%0b ctrl=%h halted=%0b expected 1 0000 0",
                     busy_a, ctrl_a, halted_a);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (halted_a !== 1'b1 || busy_a !== 1'b0 || req_a !== 1'b0 || pc_a !== 8'd3) begin
            errors++;
            $display("FAIL halt_edge_final: halted=%0b busy=%0b req=%0b pc=%h expected 1 0 0 03",
                     halted_a, busy_a, req_a, pc_a);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        wrap_pass_b = 1'b0;
        qb_ctrl.delete();
        qb_data.delete();
        qb_pc.delete();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        #1;
        while (!halted_b && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (halted_b !== 1'b1 || pc_b !== 2'd0) begin
            errors++;
            $display("FAIL wrap_final: halted=%0b pc=%0d expected 1 0", halted_b, pc_b);
        end
        checks++;
        if (qb_ctrl.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d exec words, expected 4", qb_ctrl.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qb_ctrl[i] !== 14'h0020 || qb_data[i] !== 4'd1 || qb_pc[i] !== 2'(i)) begin
                    errors++;
                    $display("FAIL wrap_exec%0d: control=%h data=%h pc=%0d expected 0020 1 %0d",
                             i, qb_ctrl[i], qb_data[i], qb_pc[i], i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_program(1, "prog_lat1");
        test_program(3, "prog_lat3");
        test_jump();
        test_back_to_back();
        test_restart();
        test_halt_start_edge();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
